// File: rtl/mcu_el2_pkg.sv
// mcu_el2_pkg: shared types and constants for the bus clock-enable generator
package mcu_el2_pkg;
  typedef enum logic {RUN, DRAIN} fsm_t;
  localparam int LSU = 0;
  localparam int IFU = 1;
  localparam int DBG = 2;
  localparam int DMA = 3;
  localparam int DEF_RATIO = 0;
endpackage

// File: rtl/mcu_el2_bus_clken_gen_if.sv
// mcu_el2_bus_clken_gen_if: ratio handshake and bus enable signals
interface mcu_el2_bus_clken_gen_if #(parameter int RATIO_W = 3, parameter int NUM_BUS = 4);
  logic ratio_req;
  logic [RATIO_W-1:0] ratio_new;
  logic ratio_ack;
  logic ratio_err;
  logic bus_idle;
  logic [NUM_BUS-1:0] bus_en_mask;
  logic scan_mode;
  logic [NUM_BUS-1:0] bus_clk_en;
  logic [RATIO_W-1:0] ratio_cur;
  logic [RATIO_W-1:0] bus_cnt;
  modport master(output ratio_req, ratio_new, bus_idle, bus_en_mask, scan_mode,
                 input ratio_ack, ratio_err, bus_clk_en, ratio_cur, bus_cnt);
  modport slave(input ratio_req, ratio_new, bus_idle, bus_en_mask, scan_mode,
                output ratio_ack, ratio_err, bus_clk_en, ratio_cur, bus_cnt);
endinterface

// File: rtl/mcu_el2_bus_clken_div.sv
// mcu_el2_bus_clken_div: period counter with ratio load; en is high on the last cycle of each period
module mcu_el2_bus_clken_div import mcu_el2_pkg::*; #(parameter int RATIO_W = 3) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic [RATIO_W-1:0] ratio_load,
  output logic [RATIO_W-1:0] cnt,
  output logic [RATIO_W-1:0] ratio,
  output logic en,
  output logic boundary
);
  logic [RATIO_W-1:0] cnt_next, ratio_next;
  always_comb begin
    boundary = cnt == ratio;
    ratio_next = load ? ratio_load : ratio;
    cnt_next = (boundary | load) ? '0 : cnt + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      ratio <= RATIO_W'(DEF_RATIO);
      en <= 1'b0;
    end else begin
      cnt <= cnt_next;
      ratio <= ratio_next;
      en <= cnt_next == ratio_next;
    end
  end
endmodule

// File: rtl/mcu_el2_bus_clken_gen.sv
// mcu_el2_bus_clken_gen: core-to-bus clock enables with handshaked run-time ratio change
module mcu_el2_bus_clken_gen import mcu_el2_pkg::*; #(
  parameter int RATIO_W = 3,
  parameter int TMO_W = 8,
  parameter int NUM_BUS = 4
) (
  input logic clk,
  input logic rst,
  mcu_el2_bus_clken_gen_if.slave bus
);
  fsm_t state_q, state_d;
  logic [RATIO_W-1:0] pend_q, pend_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic ack_d, err_d, load, en, boundary;
  mcu_el2_bus_clken_div #(.RATIO_W(RATIO_W)) u_div (
    .clk(clk),
    .rst(rst),
    .load(load),
    .ratio_load(pend_q),
    .cnt(bus.bus_cnt),
    .ratio(bus.ratio_cur),
    .en(en),
    .boundary(boundary)
  );
  // a switch only happens on a boundary, where en is already high, so no short period
  always_comb begin
    state_d = state_q;
    pend_d = pend_q;
    tmo_d = tmo_q;
    ack_d = 1'b0;
    err_d = 1'b0;
    load = 1'b0;
    if (state_q == RUN) begin
      if (bus.ratio_req) begin
        pend_d = bus.ratio_new;
        tmo_d = '0;
        state_d = DRAIN;
      end
    end else if (boundary) begin
      if (bus.bus_idle) begin
        load = 1'b1;
        ack_d = 1'b1;
        state_d = RUN;
      end else begin
        tmo_d = tmo_q + 1'b1;
        err_d = &tmo_d;
        state_d = err_d ? RUN : DRAIN;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pend_q <= '0;
      tmo_q <= '0;
      bus.ratio_ack <= 1'b0;
      bus.ratio_err <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q <= pend_d;
      tmo_q <= tmo_d;
      bus.ratio_ack <= ack_d;
      bus.ratio_err <= err_d;
    end
  end
  assign bus.bus_clk_en = ({NUM_BUS{en}} & ~bus.bus_en_mask) | {NUM_BUS{bus.scan_mode}};
endmodule

// File: tb/tb_mcu_el2_bus_clken_gen.sv
// tb_mcu_el2_bus_clken_gen: cycle model feeds an expectation queue checked against the DUT
module tb_mcu_el2_bus_clken_gen;
  localparam int RW = 3;
  localparam int TW = 3;
  localparam int NB = 4;
  localparam int TMAX = (1 << TW) - 1;
  typedef struct {
    logic [NB-1:0] en;
    logic [RW-1:0] rc;
    logic [RW-1:0] cnt;
    logic ack;
    logic err;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  mcu_el2_bus_clken_gen_if #(.RATIO_W(RW), .NUM_BUS(NB)) bus ();
  mcu_el2_bus_clken_gen #(.RATIO_W(RW), .TMO_W(TW), .NUM_BUS(NB)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  exp_t q[$];
  int errors = 0;
  int checks = 0;
  int m_ph = 0, m_rc = 0, m_pend = 0, m_tmo = 0;
  bit m_en = 0, m_drain = 0, m_ack = 0, m_err = 0;
  int n_ack = 0, n_err = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model();
    bit bnd, app, tout;
    if (rst) begin
      m_ph = 0; m_rc = 0; m_pend = 0; m_tmo = 0;
      m_en = 0; m_drain = 0; m_ack = 0; m_err = 0;
    end else begin
      bnd = m_ph == m_rc;
      app = m_drain && bnd && bus.bus_idle;
      tout = m_drain && bnd && !bus.bus_idle && (m_tmo + 1 == TMAX);
      m_ack = app;
      m_err = tout;
      if (!m_drain && bus.ratio_req) begin
        m_pend = int'(bus.ratio_new);
        m_tmo = 0;
        m_drain = 1;
      end else if (m_drain && bnd && !bus.bus_idle) m_tmo++;
      if (app || tout) m_drain = 0;
      m_ph = bnd ? 0 : m_ph + 1;
      if (app) m_rc = m_pend;
      m_en = m_ph == m_rc;
    end
  endtask
  task automatic step();
    exp_t e, o;
    model();
    e.en = ({NB{m_en}} & ~bus.bus_en_mask) | {NB{bus.scan_mode}};
    e.rc = RW'(m_rc);
    e.cnt = RW'(m_ph);
    e.ack = m_ack;
    e.err = m_err;
    q.push_back(e);
    @(posedge clk);
    #1;
    o = q.pop_front();
    check("bus_clk_en", 32'(bus.bus_clk_en), 32'(o.en));
    check("ratio_cur", 32'(bus.ratio_cur), 32'(o.rc));
    check("bus_cnt", 32'(bus.bus_cnt), 32'(o.cnt));
    check("ratio_ack", 32'(bus.ratio_ack), 32'(o.ack));
    check("ratio_err", 32'(bus.ratio_err), 32'(o.err));
    if (bus.ratio_ack === 1'b1 && bus.ratio_err === 1'b1) check("ack_err_excl", 1, 0);
    n_ack += int'(bus.ratio_ack === 1'b1);
    n_err += int'(bus.ratio_err === 1'b1);
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask
  task automatic wait_done(input string tag, input bit want_ack);
    bit got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      step();
      got = (want_ack ? m_ack : m_err) && (want_ack ? bus.ratio_ack : bus.ratio_err);
    end
    bus.ratio_req = 1'b0;
    check(tag, 32'(got), 1);
  endtask
  initial begin
    bus.ratio_req = 1'b0;
    bus.ratio_new = '0;
    bus.bus_idle = 1'b1;
    bus.bus_en_mask = '0;
    bus.scan_mode = 1'b0;
    run(2);
    check("rst_en", 32'(bus.bus_clk_en), 0);
    rst = 1'b0;
    run(6);
    check("r0_en", 32'(bus.bus_clk_en), 32'hF);
    bus.ratio_new = 3'd3;
    bus.ratio_req = 1'b1;
    wait_done("ack_r3", 1);
    run(12);
    check("r3_cur", 32'(bus.ratio_cur), 3);
    bus.bus_idle = 1'b0;
    bus.ratio_new = 3'd1;
    bus.ratio_req = 1'b1;
    run(8);
    bus.ratio_new = 3'd5;
    run(12);
    bus.bus_idle = 1'b1;
    wait_done("ack_r1", 1);
    run(10);
    check("r1_cur", 32'(bus.ratio_cur), 1);
    bus.bus_idle = 1'b0;
    bus.ratio_new = 3'd2;
    bus.ratio_req = 1'b1;
    wait_done("err_tmo", 0);
    bus.bus_idle = 1'b1;
    run(4);
    check("tmo_keep", 32'(bus.ratio_cur), 1);
    bus.bus_en_mask = 4'b0101;
    run(6);
    bus.scan_mode = 1'b1;
    run(4);
    check("scan_en", 32'(bus.bus_clk_en), 32'hF);
    bus.scan_mode = 1'b0;
    bus.bus_en_mask = '0;
    bus.bus_idle = 1'b0;
    bus.ratio_new = 3'd3;
    bus.ratio_req = 1'b1;
    run(3);
    rst = 1'b1;
    bus.ratio_req = 1'b0;
    run(1);
    rst = 1'b0;
    bus.bus_idle = 1'b1;
    run(8);
    check("rst_cur", 32'(bus.ratio_cur), 0);
    check("n_ack", 32'(n_ack), 2);
    check("n_err", 32'(n_err), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
